// File: rtl/dm_sba_master_if.sv
// System-bus side of the SBA master: one request/grant/response channel, 32-bit data.
interface dm_sba_master_if;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic        err_i;
  logic [31:0] rdata_i;

  modport master (
    output req_o, we_o, addr_o, be_o, wdata_o,
    input  gnt_i, rvalid_i, err_i, rdata_i
  );

  modport slave (
    input  req_o, we_o, addr_o, be_o, wdata_o,
    output gnt_i, rvalid_i, err_i, rdata_i
  );
endinterface

// File: rtl/dm_sba_master.sv
// Debug-module System Bus Access master: one bus transaction per register-block trigger.
// Optional access timeout enabled by defining DM_SBA_TIMEOUT_EN.
module dm_sba_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] sbaddress_i,
  input  logic [31:0] sbdata_i,
  input  logic [2:0]  sbaccess_i,
  input  logic        sbautoincrement_i,
  input  logic        sbreadondata_i,
  input  logic        sbreadonaddr_i,
  input  logic        sbaddress_write_valid_i,
  input  logic        sbdata_read_valid_i,
  input  logic        sbdata_write_valid_i,
  output logic        sbbusy_o,
  output logic        sbbusyerror_o,
  output logic [2:0]  sberror_o,
  output logic        sberror_valid_o,
  output logic [31:0] sbdata_o,
  output logic        sbdata_valid_o,
  output logic [31:0] sbaddress_o,
  output logic        sbaddress_valid_o,
  dm_sba_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      r_state, w_state;
  logic [31:0] r_addr, r_wdata, r_sbdata, r_sbaddress;
  logic [3:0]  r_be;
  logic [1:0]  r_size;
  logic        r_we, r_autoinc, r_busyerr;
  logic [2:0]  r_sberror;

  logic        w_trig_wr, w_trig, w_fin;
  logic [2:0]  w_pre_err, w_code;
  logic [31:0] w_wdata, w_rshift, w_rdata;
  logic [3:0]  w_be;

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_cnt, w_cnt;
`endif

  // Priority decode: a write strobe masks any read trigger in the same cycle.
  always_comb begin
    w_trig_wr = sbdata_write_valid_i;
    w_trig    = w_trig_wr | (sbaddress_write_valid_i & sbreadonaddr_i) |
                (sbdata_read_valid_i & sbreadondata_i);
    if (sbaccess_i > 3'd2) begin
      w_pre_err = 3'd4;
    end else if ((sbaccess_i == 3'd1 && sbaddress_i[0]) ||
                 (sbaccess_i == 3'd2 && sbaddress_i[1:0] != 2'b00)) begin
      w_pre_err = 3'd3;
    end else begin
      w_pre_err = 3'd0;
    end
    unique case (sbaccess_i[1:0])
      2'd0:    begin w_wdata = {4{sbdata_i[7:0]}};  w_be = 4'b0001 << sbaddress_i[1:0]; end
      2'd1:    begin w_wdata = {2{sbdata_i[15:0]}}; w_be = 4'b0011 << sbaddress_i[1:0]; end
      default: begin w_wdata = sbdata_i;            w_be = 4'hF;                        end
    endcase
    w_rshift = bus.rdata_i >> {r_addr[1:0], 3'b000};
    unique case (r_size)
      2'd0:    w_rdata = {24'd0, w_rshift[7:0]};
      2'd1:    w_rdata = {16'd0, w_rshift[15:0]};
      default: w_rdata = w_rshift;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_fin   = 1'b0;
    w_code  = 3'd0;
    unique case (r_state)
      StIdle: begin
        if (w_trig) begin
          if (w_pre_err != 3'd0) begin
            w_state = StDone;
            w_fin   = 1'b1;
            w_code  = w_pre_err;
          end else begin
            w_state = StReq;
          end
        end
      end
      StReq:  if (bus.gnt_i) w_state = StWait;
      StWait: begin
        if (bus.rvalid_i) begin
          w_state = StDone;
          w_fin   = 1'b1;
          w_code  = bus.err_i ? 3'd2 : 3'd0;
        end
      end
      StDone:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
`ifdef DM_SBA_TIMEOUT_EN
    w_cnt = '0;
    if (r_state == StReq || r_state == StWait) begin
      // Timeout overrides a same-cycle grant or response.
      if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
        w_state = StDone;
        w_fin   = 1'b1;
        w_code  = 3'd1;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
`ifdef DM_SBA_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state;
`ifdef DM_SBA_TIMEOUT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_size      <= '0;
      r_we        <= 1'b0;
      r_autoinc   <= 1'b0;
      r_busyerr   <= 1'b0;
      r_sberror   <= '0;
      r_sbdata    <= '0;
      r_sbaddress <= '0;
    end else begin
      r_busyerr <= w_trig & (r_state != StIdle);
      if (r_state == StIdle && w_trig) begin
        r_addr    <= sbaddress_i;
        r_wdata   <= w_wdata;
        r_be      <= w_be;
        r_size    <= sbaccess_i[1:0];
        r_we      <= w_trig_wr;
        r_autoinc <= sbautoincrement_i;
      end
      if (w_fin) begin
        r_sberror <= w_code;
        if (w_code == 3'd0 && !r_we) r_sbdata <= w_rdata;
        if (w_code == 3'd0 && r_autoinc) r_sbaddress <= r_addr + (32'd1 << r_size);
      end
    end
  end

  always_comb begin
    sbbusy_o          = (r_state != StIdle);
    sbbusyerror_o     = r_busyerr;
    sberror_o         = r_sberror;
    sberror_valid_o   = (r_state == StDone);
    sbdata_o          = r_sbdata;
    sbdata_valid_o    = (r_state == StDone) & ~r_we & (r_sberror == 3'd0);
    sbaddress_o       = r_sbaddress;
    sbaddress_valid_o = (r_state == StDone) & r_autoinc & (r_sberror == 3'd0);
    bus.req_o         = (r_state == StReq);
    bus.we_o          = r_we;
    bus.addr_o        = {r_addr[31:2], 2'b00};
    bus.be_o          = r_be;
    bus.wdata_o       = r_wdata;
  end

endmodule

// File: tb/tb_dm_sba_master.sv
// Scoreboard bench for dm_sba_master: expected completions queued at trigger, checked on DONE.
module tb_dm_sba_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] sbaddress_i = '0, sbdata_i = '0;
  logic [2:0]  sbaccess_i = '0;
  logic        sbautoincrement_i = 1'b0, sbreadondata_i = 1'b0, sbreadonaddr_i = 1'b0;
  logic        sbaddress_write_valid_i = 1'b0, sbdata_read_valid_i = 1'b0;
  logic        sbdata_write_valid_i = 1'b0;
  logic        sbbusy_o, sbbusyerror_o, sberror_valid_o, sbdata_valid_o, sbaddress_valid_o;
  logic [2:0]  sberror_o;
  logic [31:0] sbdata_o, sbaddress_o;

  dm_sba_master_if bus ();

  dm_sba_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .sbaddress_i             (sbaddress_i),
    .sbdata_i                (sbdata_i),
    .sbaccess_i              (sbaccess_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbbusy_o                (sbbusy_o),
    .sbbusyerror_o           (sbbusyerror_o),
    .sberror_o               (sberror_o),
    .sberror_valid_o         (sberror_valid_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbaddress_o             (sbaddress_o),
    .sbaddress_valid_o       (sbaddress_valid_o),
    .bus                     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  code;
    logic        dv;
    logic [31:0] data;
    logic        av;
    logic [31:0] addr;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_gnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && bus.req_o && bus.gnt_i) n_gnt++;
    if (rst_ni && sberror_valid_o) begin
      if (q_exp.size() == 0) begin
        check_val("spurious_done", {31'd0, sberror_valid_o}, 32'd0);
      end else begin
        exp_t x;
        x = q_exp.pop_front();
        check_val("sberror", {29'd0, sberror_o}, {29'd0, x.code});
        check_val("sbdata_valid", {31'd0, sbdata_valid_o}, {31'd0, x.dv});
        if (x.dv) check_val("sbdata", sbdata_o, x.data);
        check_val("sbaddress_valid", {31'd0, sbaddress_valid_o}, {31'd0, x.av});
        if (x.av) check_val("sbaddress", sbaddress_o, x.addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // kind: 0 write, 1 read-on-address, 2 read-on-data.
  task automatic do_access(input int kind, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz, input logic ainc, input logic [31:0] rd,
                           input logic e, input int gdly, input logic poke, input logic dual);
    exp_t        x;
    logic [2:0]  pre;
    logic [31:0] sh, ebe, ewd;
    int          g0;
    pre = 3'd0;
    if (sz > 3'd2) pre = 3'd4;
    else if ((sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)) pre = 3'd3;
    sh = rd >> (8 * a[1:0]);
    case (sz)
      3'd0:    begin x.data = sh & 32'hFF;   ebe = 32'(4'b0001 << a[1:0]); ewd = {4{d[7:0]}};  end
      3'd1:    begin x.data = sh & 32'hFFFF; ebe = 32'(4'b0011 << a[1:0]); ewd = {2{d[15:0]}}; end
      default: begin x.data = sh;            ebe = 32'hF;                  ewd = d;            end
    endcase
    x.code = (pre != 3'd0) ? pre : (e ? 3'd2 : 3'd0);
    x.dv   = (kind != 0) && (x.code == 3'd0);
    x.av   = ainc && (x.code == 3'd0);
    x.addr = a + (32'd1 << sz);
    q_exp.push_back(x);
    g0 = n_gnt;

    sbaddress_i             = a;
    sbdata_i                = d;
    sbaccess_i              = sz;
    sbautoincrement_i       = ainc;
    sbreadonaddr_i          = (kind == 1) || dual;
    sbreadondata_i          = (kind == 2);
    sbdata_write_valid_i    = (kind == 0);
    sbaddress_write_valid_i = (kind == 1) || dual;
    sbdata_read_valid_i     = (kind == 2);
    tick();
    sbdata_write_valid_i    = 1'b0;
    sbaddress_write_valid_i = 1'b0;
    sbdata_read_valid_i     = 1'b0;

    if (pre != 3'd0) begin
      check_val("pre_noreq", {31'd0, bus.req_o}, 32'd0);
      check_val("pre_busy", {31'd0, sbbusy_o}, 32'd1);
      tick();
      check_val("pre_idle", {31'd0, sbbusy_o}, 32'd0);
      return;
    end

    check_val("req_next", {31'd0, bus.req_o}, 32'd1);
    check_val("busy_next", {31'd0, sbbusy_o}, 32'd1);
    check_val("we", {31'd0, bus.we_o}, (kind == 0) ? 32'd1 : 32'd0);
    check_val("addr", bus.addr_o, {a[31:2], 2'b00});
    check_val("be", {28'd0, bus.be_o}, ebe);
    if (kind == 0) check_val("wdata", bus.wdata_o, ewd);
    repeat (gdly) tick();
    if (gdly > 0) check_val("req_hold", {31'd0, bus.req_o}, 32'd1);
    bus.gnt_i = 1'b1;
    tick();
    bus.gnt_i = 1'b0;
    check_val("req_drop", {31'd0, bus.req_o}, 32'd0);
    if (poke) begin
      sbdata_write_valid_i = 1'b1;
      tick();
      sbdata_write_valid_i = 1'b0;
      check_val("busyerror", {31'd0, sbbusyerror_o}, 32'd1);
    end
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = rd;
    bus.err_i    = e;
    tick();
    bus.rvalid_i = 1'b0;
    bus.err_i    = 1'b0;
    check_val("busy_done", {31'd0, sbbusy_o}, 32'd1);
    tick();
    check_val("busy_drop", {31'd0, sbbusy_o}, 32'd0);
    check_val("one_grant", 32'(n_gnt - g0), 32'd1);
  endtask

  initial begin
    bus.gnt_i    = 1'b0;
    bus.rvalid_i = 1'b0;
    bus.err_i    = 1'b0;
    bus.rdata_i  = '0;
    repeat (2) tick();
    check_val("rst_busy", {31'd0, sbbusy_o}, 32'd0);
    check_val("rst_req", {31'd0, bus.req_o}, 32'd0);
    check_val("rst_be", {28'd0, bus.be_o}, 32'd0);
    check_val("rst_sbaddress", sbaddress_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    //        kind addr          data          sz ainc rdata         err gd poke dual
    do_access(0, 32'h0010_0000, 32'hAABBCCDD, 2, 0, 32'h0,        0, 0, 0, 0);
    check_val("ww_be", {28'd0, bus.be_o}, 32'hF);
    do_access(1, 32'h0010_0003, 32'h0,        0, 0, 32'h11223344, 0, 1, 0, 0);
    check_val("rb_data", sbdata_o, 32'h0000_0011);
    do_access(2, 32'h0000_1000, 32'h0,        1, 1, 32'hCAFE1234, 0, 2, 0, 0);
    check_val("rh_addr", sbaddress_o, 32'h0000_1002);
    do_access(1, 32'hFFFF_FFFC, 32'h0,        2, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    check_val("wrap_addr", sbaddress_o, 32'h0);
    do_access(0, 32'h0000_0002, 32'h0000005A, 0, 1, 32'h0,        0, 0, 0, 0);
    do_access(0, 32'h0000_0002, 32'h1234ABCD, 1, 0, 32'h0,        0, 3, 0, 0);
    do_access(1, 32'h0000_0006, 32'h0,        1, 0, 32'h89AB4567, 0, 0, 0, 0);
    do_access(0, 32'h0000_1001, 32'h0,        2, 0, 32'h0,        0, 0, 0, 0);
    do_access(1, 32'h0000_0003, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0);
    do_access(2, 32'h0000_0000, 32'h0,        3, 0, 32'h0,        0, 0, 0, 0);
    do_access(1, 32'h0000_0010, 32'h0,        2, 1, 32'h55555555, 1, 1, 0, 0);
    do_access(0, 32'h0000_0020, 32'h01020304, 2, 0, 32'h0,        0, 0, 1, 0);
    do_access(0, 32'h0000_0024, 32'h0A0B0C0D, 2, 0, 32'h0,        0, 0, 0, 1);

    // Stray response while idle must not produce a completion.
    bus.rvalid_i = 1'b1;
    tick();
    bus.rvalid_i = 1'b0;
    tick();
    check_val("stray_idle", {31'd0, sbbusy_o}, 32'd0);

`ifdef DM_SBA_TIMEOUT_EN
    begin
      exp_t x;
      x.code = 3'd1; x.dv = 1'b0; x.data = '0; x.av = 1'b0; x.addr = '0;
      q_exp.push_back(x);
      sbaddress_i = 32'h40; sbaccess_i = 3'd2; sbautoincrement_i = 1'b0;
      sbdata_write_valid_i = 1'b1;
      tick();
      sbdata_write_valid_i = 1'b0;
      repeat (15) tick();
      check_val("to_req_hold", {31'd0, bus.req_o}, 32'd1);
      tick();
      check_val("to_req_low", {31'd0, bus.req_o}, 32'd0);
      tick();
      bus.rvalid_i = 1'b1;
      tick();
      bus.rvalid_i = 1'b0;
      tick();
      check_val("to_idle", {31'd0, sbbusy_o}, 32'd0);
    end
`endif

    // Reset mid-access: request drops at once and no completion follows.
    sbaddress_i = 32'h80; sbaccess_i = 3'd2; sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    check_val("mid_req", {31'd0, bus.req_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_val("mid_rst_req", {31'd0, bus.req_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    check_val("mid_rst_busy", {31'd0, sbbusy_o}, 32'd0);

    check_val("drain", 32'(q_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
